pipe_arb: RTL and testbench
===========================

PIPE_ARB -- requirements
Module: pipe_arb

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the pipeline (legal 2..8).
REQ-002 Parameter B, default 8, data width in bits.
REQ-003 Parameter L, default 2, latency in cycles of the external shared pipeline from pipe_din to pipe_dout (legal 1..16).
REQ-004 Parameter BURST, default 4, maximum consecutive grants to one requester while others wait (legal 1..15).
REQ-005 Port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 Port rst, input, 1, reset, synchronous and active-high.
REQ-007 Port req_valid, input, NREQ, bit i: requester i presents a word.
REQ-008 Port req_data, input, NREQ*B, requester i word at bits [i*B +: B].
REQ-009 Port req_ready, output, NREQ, one-hot or zero grant; bit i high means requester i's word is accepted this cycle if req_valid[i].
REQ-010 Port pipe_din, output, B, registered word to the shared pipeline input.
REQ-011 Port pipe_vld, output, 1, registered qualifier for pipe_din.
REQ-012 Port pipe_dout, input, B, shared pipeline output, valid exactly L cycles after pipe_din.
REQ-013 Port rsp_valid, output, NREQ, one-hot or zero; bit i marks rsp_data as requester i's result.
REQ-014 Port rsp_data, output, B, equal to pipe_dout.
REQ-015 Port flush, input, 1, level request to stop granting and drain the pipeline.
REQ-016 Port flush_done, output, 1, pipeline empty while flush is held.
REQ-017 Port busy, output, 1, any word in flight (pipe_vld or any tag stage valid).

Function
REQ-018 Accept: requester i accepted in cycle t when req_valid[i] & req_ready[i]; pipe_vld=1, pipe_din=its word in cycle t+1; pipe_vld=0 in any cycle following a cycle with no accept.
REQ-019 Tagging: a shift register of depth L, parallel to the external pipeline, carries {valid, index} entered at t+1, so rsp_valid[i]=1 in cycle t+1+L; total accept-to-response latency L+1.
REQ-020 rsp_valid is driven only from the tag shift register; pipe_dout is never qualified by any other source.
REQ-021 Arbitration: round-robin; search starts at index after the last granted requester (ptr+1 mod NREQ); req_ready combinational from req_valid, ptr, burst count, state, flush.
REQ-022 Burst: current owner keeps the grant while req_valid stays high and burst count < BURST; count increments per accept, resets to 1 on owner change.
REQ-023 Burst expiry with no other requester valid: owner keeps the grant and count restarts at 1; no idle cycle inserted.
REQ-024 Owner dropping req_valid: grant moves in the same cycle to the next valid requester in round-robin order.
REQ-025 Throughput: one accept per cycle whenever any req_valid is high and state is RUN with flush low.
REQ-026 FSM states RUN, DRAIN, DONE; reset enters RUN.
REQ-027 RUN -> DRAIN when flush=1; DRAIN -> DONE when busy=0; DONE -> RUN when flush=0; DRAIN -> RUN if flush drops before empty.
REQ-028 req_ready=0 whenever flush=1 or state is not RUN, including the cycle flush first rises.
REQ-029 flush_done=1 exactly while state is DONE; first high the cycle after the last rsp_valid.
REQ-030 In-flight count fits 0..L+1; no overflow or wrap possible given one accept per cycle.

Reset
REQ-031 While rst=1: req_ready=0, pipe_vld=0, pipe_din=0, all tag stages invalid, rsp_valid=0, flush_done=0, busy=0, burst count=0, ptr=NREQ-1 (requester 0 served first), state RUN.
REQ-032 Reset mid-operation discards all in-flight words; no rsp_valid for any word accepted before reset.

Verification (NREQ=4, B=8, L=2, BURST=4, pipe_dout looped through an L-stage delay)
REQ-033 Single: req_valid=0001, req_data[7:0]=0x5A at cycle t -> req_ready=0001 at t; pipe_vld=1, pipe_din=0x5A at t+1; rsp_valid=0001, rsp_data=0x5A at t+3.
REQ-034 Contention: req_valid=1111 held 16 cycles -> grant order 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3; accept every cycle.
REQ-035 Solo stream: only requester 2 valid for 10 cycles -> 10 consecutive grants to 2, no gaps; burst restart at the 5th and 9th accept.
REQ-036 Mid-burst drop: req_valid=0011, requester 0 drops after 2 accepts -> requester 1 granted the same cycle.
REQ-037 Flush: flush raised with 2 words in flight -> req_ready=0 that cycle; two rsp_valid pulses; flush_done=1 the following cycle; flush low -> RUN, grants resume next cycle.
REQ-038 Reset mid-stream: rst=1 for one cycle with 3 words in flight -> rsp_valid stays 0 and busy=0 from the cycle after reset.

Source files
------------

// File: rtl/pipe_arb_if.sv
// Bundle of request, shared-pipeline, response and flush signals for pipe_arb.
// "master" is the environment side (requesters + external pipeline); "slave" is the arbiter.
interface pipe_arb_if #(
    parameter int NREQ = 4,
    parameter int B    = 8
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*B-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic [B-1:0]      pipe_din;
    logic              pipe_vld;
    logic [B-1:0]      pipe_dout;
    logic [NREQ-1:0]   rsp_valid;
    logic [B-1:0]      rsp_data;
    logic              flush;
    logic              flush_done;
    logic              busy;

    modport master (
        output req_valid, req_data, pipe_dout, flush,
        input  req_ready, pipe_din, pipe_vld, rsp_valid, rsp_data, flush_done, busy
    );

    modport slave (
        input  req_valid, req_data, pipe_dout, flush,
        output req_ready, pipe_din, pipe_vld, rsp_valid, rsp_data, flush_done, busy
    );
endinterface

// File: rtl/pipe_arb.sv
// Round-robin, burst-limited arbiter feeding a shared fixed-latency pipeline; a parallel
// tag shift register routes each pipeline result back to the requester that issued it.
module pipe_arb #(
    parameter int NREQ  = 4,
    parameter int B     = 8,
    parameter int L     = 2,
    parameter int BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    pipe_arb_if.slave   bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = 4;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_flush_done;
    logic [IW-1:0]   r_ptr;
    logic [CW-1:0]   r_cnt;
    logic            r_pipe_vld;
    logic [B-1:0]    r_pipe_din;
    logic [IW-1:0]   r_pipe_idx;
    logic [L-1:0]    r_tag_vld;
    logic [IW-1:0]   r_tag_idx [L];

    logic            w_found;
    logic            w_keep;
    logic [IW-1:0]   w_idx;
    logic [NREQ-1:0] w_grant;
    logic [L-1:0]    w_tag_early;
    logic            w_upstream;
    logic [NREQ-1:0] w_rsp;

    // Grant selection: keep the current owner inside its burst, otherwise scan from ptr+1.
    // The scan visits the owner last, so an expired owner with no competitor restarts its burst.
    always_comb begin
        w_found = 1'b0;
        w_keep  = 1'b0;
        w_idx   = r_ptr;
        w_grant = {NREQ{1'b0}};
        if ((r_state == ST_RUN) && !bus.flush && !rst) begin
            if (bus.req_valid[r_ptr] && (r_cnt != {CW{1'b0}}) && (r_cnt < CW'(BURST))) begin
                w_found = 1'b1;
                w_keep  = 1'b1;
            end else begin
                for (int k = 1; k <= NREQ; k++) begin
                    if (!w_found && bus.req_valid[IW'((int'(r_ptr) + k) % NREQ)]) begin
                        w_found = 1'b1;
                        w_idx   = IW'((int'(r_ptr) + k) % NREQ);
                    end else begin
                        w_found = w_found;
                    end
                end
            end
            if (w_found) begin
                w_grant[w_idx] = 1'b1;
            end else begin
                w_grant = {NREQ{1'b0}};
            end
        end else begin
            w_grant = {NREQ{1'b0}};
        end
    end

    // Anything still in flight after this edge, excluding the tag stage that retires now.
    always_comb begin
        w_tag_early        = r_tag_vld;
        w_tag_early[L-1]   = 1'b0;
        w_upstream         = r_pipe_vld | (|w_tag_early);
    end

    // Response decode from the last tag stage only.
    always_comb begin
        w_rsp = {NREQ{1'b0}};
        if (!rst && r_tag_vld[L-1]) begin
            w_rsp[r_tag_idx[L-1]] = 1'b1;
        end else begin
            w_rsp = {NREQ{1'b0}};
        end
    end

    // Pipeline input register, arbitration pointer/burst count and tag shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe_vld <= 1'b0;
            r_pipe_din <= {B{1'b0}};
            r_pipe_idx <= {IW{1'b0}};
            r_ptr      <= IW'(NREQ - 1);
            r_cnt      <= {CW{1'b0}};
            r_tag_vld  <= {L{1'b0}};
            for (int k = 0; k < L; k++) begin
                r_tag_idx[k] <= {IW{1'b0}};
            end
        end else begin
            r_pipe_vld <= w_found;
            if (w_found) begin
                r_pipe_din <= bus.req_data[int'(w_idx)*B +: B];
                r_pipe_idx <= w_idx;
                r_ptr      <= w_idx;
                r_cnt      <= w_keep ? (r_cnt + CW'(1)) : CW'(1);
            end
            r_tag_vld[0] <= r_pipe_vld;
            r_tag_idx[0] <= r_pipe_idx;
            for (int k = 1; k < L; k++) begin
                r_tag_vld[k] <= r_tag_vld[k-1];
                r_tag_idx[k] <= r_tag_idx[k-1];
            end
        end
    end

    // Flush FSM; DONE is entered on the edge after which nothing remains in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_flush_done <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (bus.flush) begin
                        r_state <= ST_DRAIN;
                    end
                    r_flush_done <= 1'b0;
                end
                ST_DRAIN: begin
                    if (!bus.flush) begin
                        r_state      <= ST_RUN;
                        r_flush_done <= 1'b0;
                    end else if (!w_upstream) begin
                        r_state      <= ST_DONE;
                        r_flush_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!bus.flush) begin
                        r_state      <= ST_RUN;
                        r_flush_done <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_RUN;
                    r_flush_done <= 1'b0;
                end
            endcase
        end
    end

    // Outputs are forced quiet during the reset cycle itself, before registers clear.
    assign bus.req_ready  = w_grant;
    assign bus.pipe_vld   = r_pipe_vld & ~rst;
    assign bus.pipe_din   = rst ? {B{1'b0}} : r_pipe_din;
    assign bus.rsp_valid  = w_rsp;
    assign bus.rsp_data   = bus.pipe_dout;
    assign bus.flush_done = r_flush_done & ~rst;
    assign bus.busy       = ~rst & (r_pipe_vld | (|r_tag_vld));

endmodule

// File: tb/tb_pipe_arb.sv
// Directed + randomized bench for pipe_arb (NREQ=4, B=8, L=2, BURST=4) against a
// transaction-level model: a list of accepted words stamped with their accept cycle.
module tb_pipe_arb;
    localparam int NREQ  = 4;
    localparam int B     = 8;
    localparam int L     = 2;
    localparam int BURST = 4;

    logic clk;
    logic rst;

    pipe_arb_if #(.NREQ(NREQ), .B(B)) bus ();

    pipe_arb #(.NREQ(NREQ), .B(B), .L(L), .BURST(BURST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External shared pipeline: pure L-stage delay of pipe_din.
    logic [B-1:0] dl [L];
    always @(posedge clk) begin
        dl[0] <= bus.pipe_din;
        for (int k = 1; k < L; k++) dl[k] <= dl[k-1];
    end
    assign bus.pipe_dout = dl[L-1];

    typedef struct {
        int         acc;
        int         idx;
        logic [7:0] data;
    } rec_t;

    rec_t q[$];
    int   m_last;
    int   m_run;
    int   m_state;      // 0 RUN, 1 DRAIN, 2 DONE
    int   cyc_n;
    int   n_total;
    int   n_pass;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc_n);
    endtask

    function automatic int m_pick(input logic [3:0] v, input logic fl);
        if (m_state != 0 || fl) return -1;
        if (m_run > 0 && m_run < BURST && v[m_last]) return m_last;
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
        end
        return -1;
    endfunction

    // One clock cycle: drive, check all outputs on the falling edge, advance the model.
    // want: -2 no directed grant check, -1 expect no grant, else expected granted index.
    task automatic cyc(input logic [3:0] v, input logic fl, input logic rs, input int want);
        int         g;
        logic       exp_pv;
        logic [7:0] exp_pd;
        logic [3:0] exp_rsp;
        logic [7:0] exp_rd;
        logic       exp_busy;
        logic       in_next;
        logic [3:0] exp_rdy;
        rst           = rs;
        bus.req_valid = v;
        bus.flush     = fl;
        for (int i = 0; i < NREQ; i++) bus.req_data[i*B +: B] = 8'($urandom);
        @(negedge clk);
        g        = rs ? -1 : m_pick(v, fl);
        exp_pv   = 1'b0;
        exp_pd   = 8'd0;
        exp_rsp  = 4'd0;
        exp_rd   = 8'd0;
        exp_busy = 1'b0;
        foreach (q[k]) begin
            if (q[k].acc == cyc_n - 1) begin
                exp_pv = 1'b1;
                exp_pd = q[k].data;
            end
            if (q[k].acc + 1 + L == cyc_n) begin
                exp_rsp[q[k].idx] = 1'b1;
                exp_rd            = q[k].data;
            end
            if (q[k].acc + 1 <= cyc_n && cyc_n <= q[k].acc + 1 + L) exp_busy = 1'b1;
        end
        if (rs) begin
            exp_pv   = 1'b0;
            exp_rsp  = 4'd0;
            exp_busy = 1'b0;
        end
        exp_rdy = (g < 0) ? 4'd0 : 4'(1 << g);
        chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        chk("pipe_vld", 32'(bus.pipe_vld), 32'(exp_pv));
        if (exp_pv) chk("pipe_din", 32'(bus.pipe_din), 32'(exp_pd));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rsp));
        if (exp_rsp != 4'd0) chk("rsp_data", 32'(bus.rsp_data), 32'(exp_rd));
        chk("busy", 32'(bus.busy), 32'(exp_busy));
        chk("flush_done", 32'(bus.flush_done), 32'(!rs && m_state == 2));
        if (want != -2) chk("dir_grant", 32'(bus.req_ready), (want < 0) ? 32'd0 : 32'(1 << want));
        if (rs) begin
            q.delete();
            m_last  = NREQ - 1;
            m_run   = 0;
            m_state = 0;
        end else begin
            if (g >= 0) begin
                if (g == m_last && m_run > 0 && m_run < BURST) m_run++;
                else m_run = 1;
                m_last = g;
                q.push_back('{cyc_n, g, bus.req_data[g*B +: B]});
            end
            in_next = 1'b0;
            foreach (q[k]) begin
                if (q[k].acc + 1 <= cyc_n + 1 && cyc_n + 1 <= q[k].acc + 1 + L) in_next = 1'b1;
            end
            case (m_state)
                0: if (fl) m_state = 1;
                1: if (!fl) m_state = 0; else if (!in_next) m_state = 2;
                2: if (!fl) m_state = 0;
                default: m_state = 0;
            endcase
            while (q.size() > 0 && q[0].acc + 1 + L < cyc_n) void'(q.pop_front());
        end
        cyc_n++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic       fl_r;
        logic [3:0] v_r;
        n_total       = 0;
        n_pass        = 0;
        cyc_n         = 0;
        m_last        = NREQ - 1;
        m_run         = 0;
        m_state       = 0;
        rst           = 1'b1;
        bus.req_valid = 4'd0;
        bus.req_data  = 32'd0;
        bus.flush     = 1'b0;
        @(posedge clk);
        #1;

        // Reset state, then a single isolated transaction.
        cyc(4'b0000, 1'b0, 1'b1, -1);
        cyc(4'b0000, 1'b0, 1'b1, -1);
        cyc(4'b0000, 1'b0, 1'b0, -1);
        cyc(4'b0001, 1'b0, 1'b0, 0);
        for (int i = 0; i < 4; i++) cyc(4'b0000, 1'b0, 1'b0, -1);

        // All four contending from a fresh reset: bursts of four in index order.
        cyc(4'b0000, 1'b0, 1'b1, -1);
        for (int k = 0; k < 16; k++) cyc(4'b1111, 1'b0, 1'b0, k / 4);

        // Lone requester streams with no gaps through burst expiry.
        for (int k = 0; k < 10; k++) cyc(4'b0100, 1'b0, 1'b0, 2);

        // Owner drops mid-burst: grant moves in the same cycle.
        cyc(4'b0011, 1'b0, 1'b0, 0);
        cyc(4'b0011, 1'b0, 1'b0, 0);
        cyc(4'b0010, 1'b0, 1'b0, 1);
        cyc(4'b0011, 1'b0, 1'b0, 1);

        // Flush with words in flight, hold, release.
        cyc(4'b1111, 1'b0, 1'b0, -2);
        for (int k = 0; k < 6; k++) cyc(4'b1111, 1'b1, 1'b0, -1);
        cyc(4'b1111, 1'b0, 1'b0, -1);
        cyc(4'b1111, 1'b0, 1'b0, -2);
        cyc(4'b1111, 1'b0, 1'b0, -2);

        // Reset with words in flight: nothing may emerge afterwards.
        cyc(4'b1111, 1'b0, 1'b0, -2);
        cyc(4'b1111, 1'b0, 1'b1, -1);
        for (int k = 0; k < 4; k++) cyc(4'b0000, 1'b0, 1'b0, -1);

        // Randomized traffic with sporadic flush windows and resets.
        fl_r = 1'b0;
        for (int k = 0; k < 400; k++) begin
            v_r = 4'($urandom);
            if ($urandom_range(0, 11) == 0) fl_r = ~fl_r;
            cyc(v_r, fl_r, ($urandom_range(0, 79) == 0), -2);
        end
        cyc(4'b0000, 1'b0, 1'b0, -2);
        for (int k = 0; k < 4; k++) cyc(4'b0000, 1'b0, 1'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
